motor_cmd_sequencer: RTL and testbench
======================================

Name: motor_cmd_sequencer

Overview:
Sequences drive commands into the torque display/drive stage. It accepts one command at a time over a valid/ready handshake. For each command it generates enable, instruction and torque with a soft-start ramp, a timed hold and a soft-stop ramp. It sits between the user-input decoder (switches/keys) and the torque display block, and an emergency stop overrides it at all times.

Parameters:
TICK_DIV, 50000, clock cycles per ramp/hold tick (≥2; bench uses 4)
DUR_W, 8, width of the hold-duration field in ticks

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_dir  in  2  00 fwd, 01 rev, 10 left, 11 right
cmd_torque  in  2  target torque level 0..3
cmd_duration  in  DUR_W  hold length in ticks
estop  in  1  emergency stop, level-sensitive
enable  out  1  to torque display enable
instruction  out  2  to torque display instruction
torque  out  2  to torque display torque
busy  out  1  command in progress (RAMP_UP/HOLD/RAMP_DOWN)
done  out  1  one-cycle pulse on normal completion
fault  out  1  high while in FAULT

Behaviour:
- Reset (rst_n low at an edge): state IDLE, enable 0, instruction 00, torque 00, done 0, fault 0, prescaler 0, hold counter 0.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, FAULT.
- cmd_ready = (state==IDLE) && !estop. It is combinational, so it is 1 during reset.
- Accept happens at an edge where cmd_valid && cmd_ready (call it cycle N). Effects visible at N+1:
  - instruction <= cmd_dir, enable <= 1, torque <= 0, target latched, duration latched, prescaler <= 0.
  - Next state RAMP_UP if target≠0; otherwise HOLD with hold counter = duration.
- Instruction is constant from accept until the next accept. It never changes mid-command.
- Prescaler: counts 0..TICK_DIV-1 while busy and wraps. tick = busy && prescaler==TICK_DIV-1. All updates below happen at the edge ending a tick cycle.
- RAMP_UP, on tick:
  - torque <= torque+1.
  - If torque+1==target, go to HOLD and set hold counter = duration.
- HOLD, on tick:
  - If hold counter≠0, decrement it.
  - Else if torque≠0, go to RAMP_DOWN.
  - Else (torque==0), go to IDLE: enable <= 0, done <= 1.
- RAMP_DOWN, on tick:
  - torque <= torque-1.
  - If torque-1==0, go to IDLE: enable <= 0, done <= 1.
- done is high for exactly one cycle, the first IDLE cycle. It is 0 otherwise.
- Torque is never ramped directly between nonzero levels of different directions. Every command starts and ends at 0.
- cmd_valid is ignored while not IDLE. There is no buffering; the upstream block holds the command until ready.
- estop high at any edge (any state, including same cycle as cmd_valid):
  - Next state FAULT, enable 0, torque 0, done 0, fault 1.
  - instruction holds its last value.
  - No command is accepted; an in-flight command is aborted with no done pulse.
- FAULT: remains while estop is high. On the first edge with estop low, go to IDLE with fault 0.
- Reset has priority over estop. Reset mid-command returns to IDLE with no done pulse.
- All outputs except cmd_ready are registered.

Test Plan:
- Full command, TICK_DIV=4: reset, accept dir=00, torque=3, duration=2 at cycle N. Required response:
  - torque=0 and enable=1 at N+1.
  - torque 1@N+5, 2@N+9, 3@N+13, held through N+28.
  - torque 2@N+29, 1@N+33, 0@N+37, with enable=0, done=1 and cmd_ready=1 at N+37.
  - done=0 at N+38.
- Zero-torque command: dir=10, torque=0, duration=1 -> enable=1 and torque=0 from N+1. IDLE with done pulse at N+9 (two ticks), no ramp states visited.
- Handshake under busy: second cmd_valid with different dir asserted throughout a running command -> cmd_ready=0, instruction unchanged until done. The second command is accepted on the first IDLE cycle and instruction updates the following cycle.
- Estop mid-HOLD: assert estop for 3 cycles -> next cycle enable=0, torque=0, fault=1, no done pulse. fault stays 1 while estop=1; IDLE and cmd_ready=1 one edge after estop drops.
- Estop with simultaneous cmd_valid in IDLE -> command not accepted, enable stays 0, FAULT entered.
- Reset mid-RAMP_UP (torque=2): rst_n low one edge -> enable=0, torque=0, instruction=00, done=0, state IDLE.

Source files
------------

// File: rtl/motor_cmd_if.sv
// Command handshake between the user-input decoder and the motor command sequencer.
interface motor_cmd_if #(
   parameter int unsigned DUR_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_dir;
   logic [1:0]       cmd_torque;
   logic [DUR_W-1:0] cmd_duration;

   modport master (
      output cmd_valid, cmd_dir, cmd_torque, cmd_duration,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_torque, cmd_duration,
      output cmd_ready
   );
endinterface

// File: rtl/motor_cmd_sequencer.sv
// Runs one drive command at a time: soft-start ramp, timed hold, soft-stop ramp,
// with a level-sensitive emergency stop that overrides everything but reset.
module motor_cmd_sequencer #(
   parameter int unsigned TICK_DIV = 50000,
   parameter int unsigned DUR_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   motor_cmd_if.slave cmd,
   input  logic       estop,
   output logic       enable,
   output logic [1:0] instruction,
   output logic [1:0] torque,
   output logic       busy,
   output logic       done,
   output logic       fault
);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [2:0] {StIdle, StRampUp, StHold, StRampDown, StFault} state_e;

   state_e           r_state, w_state_nxt;
   logic             r_enable, w_enable_nxt;
   logic [1:0]       r_instr, w_instr_nxt;
   logic [1:0]       r_torque, w_torque_nxt;
   logic [1:0]       r_target, w_target_nxt;
   logic [DUR_W-1:0] r_dur, w_dur_nxt;
   logic [DUR_W-1:0] r_hold, w_hold_nxt;
   logic [PW-1:0]    r_presc, w_presc_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_done, w_done_nxt;
   logic             r_fault, w_fault_nxt;
   logic             w_tick;
   logic [1:0]       w_torque_inc, w_torque_dec;

   assign cmd.cmd_ready  = (r_state == StIdle) && !estop;
   assign w_tick         = r_busy && (r_presc == PW'(TICK_DIV - 1));
   assign w_torque_inc   = r_torque + 2'd1;
   assign w_torque_dec   = r_torque - 2'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state  <= StIdle;
         r_enable <= 1'b0;
         r_instr  <= 2'b00;
         r_torque <= 2'b00;
         r_target <= 2'b00;
         r_dur    <= '0;
         r_hold   <= '0;
         r_presc  <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_enable <= w_enable_nxt;
         r_instr  <= w_instr_nxt;
         r_torque <= w_torque_nxt;
         r_target <= w_target_nxt;
         r_dur    <= w_dur_nxt;
         r_hold   <= w_hold_nxt;
         r_presc  <= w_presc_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_fault  <= w_fault_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_enable_nxt = r_enable;
      w_instr_nxt  = r_instr;
      w_torque_nxt = r_torque;
      w_target_nxt = r_target;
      w_dur_nxt    = r_dur;
      w_hold_nxt   = r_hold;
      w_presc_nxt  = r_presc;
      w_done_nxt   = 1'b0;
      w_fault_nxt  = 1'b0;

      if (r_busy) begin
         w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
      end

      // Emergency stop forces a safe output state; instruction keeps its last value.
      if (estop) begin
         w_state_nxt  = StFault;
         w_enable_nxt = 1'b0;
         w_torque_nxt = 2'b00;
         w_presc_nxt  = '0;
         w_fault_nxt  = 1'b1;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (cmd.cmd_valid) begin
                  w_instr_nxt  = cmd.cmd_dir;
                  w_enable_nxt = 1'b1;
                  w_torque_nxt = 2'b00;
                  w_target_nxt = cmd.cmd_torque;
                  w_dur_nxt    = cmd.cmd_duration;
                  w_presc_nxt  = '0;
                  if (cmd.cmd_torque != 2'b00) begin
                     w_state_nxt = StRampUp;
                  end else begin
                     w_state_nxt = StHold;
                     w_hold_nxt  = cmd.cmd_duration;
                  end
               end
            end
            StRampUp: begin
               if (w_tick) begin
                  w_torque_nxt = w_torque_inc;
                  if (w_torque_inc == r_target) begin
                     w_state_nxt = StHold;
                     w_hold_nxt  = r_dur;
                  end
               end
            end
            StHold: begin
               if (w_tick) begin
                  if (r_hold != '0) begin
                     w_hold_nxt = r_hold - DUR_W'(1);
                  end else if (r_torque != 2'b00) begin
                     w_state_nxt = StRampDown;
                  end else begin
                     w_state_nxt  = StIdle;
                     w_enable_nxt = 1'b0;
                     w_done_nxt   = 1'b1;
                  end
               end
            end
            StRampDown: begin
               if (w_tick) begin
                  w_torque_nxt = w_torque_dec;
                  if (w_torque_dec == 2'b00) begin
                     w_state_nxt  = StIdle;
                     w_enable_nxt = 1'b0;
                     w_done_nxt   = 1'b1;
                  end
               end
            end
            StFault: begin
               w_state_nxt = StIdle;
            end
            default: begin
               w_state_nxt  = StIdle;
               w_enable_nxt = 1'b0;
               w_torque_nxt = 2'b00;
            end
         endcase
      end

      w_busy_nxt = (w_state_nxt == StRampUp) || (w_state_nxt == StHold) ||
                   (w_state_nxt == StRampDown);
   end

   assign enable      = r_enable;
   assign instruction = r_instr;
   assign torque      = r_torque;
   assign busy        = r_busy;
   assign done        = r_done;
   assign fault       = r_fault;
endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Scoreboard bench for motor_cmd_sequencer with a short tick (TICK_DIV=4).
module tb_motor_cmd_sequencer;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned DUR_W    = 8;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       estop = 1'b0;
   logic       enable, busy, done, fault;
   logic [1:0] instruction, torque;

   motor_cmd_if #(.DUR_W(DUR_W)) cmd_if ();

   motor_cmd_sequencer #(.TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (cmd_if),
      .estop       (estop),
      .enable      (enable),
      .instruction (instruction),
      .torque      (torque),
      .busy        (busy),
      .done        (done),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [8:0] v;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Observed bundle: {busy, enable, torque, done, instruction, fault, cmd_ready}
   logic [8:0] obs;
   assign obs = {busy, enable, torque, done, instruction, fault, cmd_if.cmd_ready};

   // busy tracks enable in every scenario exercised here
   function automatic logic [8:0] ev(input logic en, input logic [1:0] tq, input logic dn,
                                     input logic [1:0] ins, input logic flt, input logic rdy);
      return {en, en, tq, dn, ins, flt, rdy};
   endfunction

   task automatic push(input int c, input logic [8:0] v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      sb.push_back(e);
   endtask

   // Called at a negedge while IDLE; returns the spec cycle number N of the accepting edge.
   task automatic accept(input logic [1:0] d, input logic [1:0] tq, input logic [DUR_W-1:0] du,
                         output int n);
      cmd_if.cmd_dir      = d;
      cmd_if.cmd_torque   = tq;
      cmd_if.cmd_duration = du;
      cmd_if.cmd_valid    = 1'b1;
      @(posedge clk);
      #1;
      n = cyc - 1;
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (obs !== ev(1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1)) begin
         n_fail++;
         $display("FAIL reset_state: got %b, expected %b", obs, ev(0, 0, 0, 0, 0, 1));
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (obs !== ev(1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1)) begin
         n_fail++;
         $display("FAIL idle_after_reset: got %b, expected %b", obs, ev(0, 0, 0, 0, 0, 1));
      end
   endtask

   task automatic test_full_cmd;
      int   n;
      exp_t e;
      logic [1:0] tq;
      accept(2'b00, 2'd3, 8'd2, n);
      for (int c = 1; c <= 38; c++) begin
         tq = (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : (c < 13) ? 2'd2 : (c < 29) ? 2'd3 :
              (c < 33) ? 2'd2 : (c < 37) ? 2'd1 : 2'd0;
         push(n + c, ev(c < 37, tq, c == 37, 2'b00, 1'b0, c >= 37));
      end
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL full_cmd N+%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
         end
      end
   endtask

   task automatic test_zero_torque;
      int   n;
      exp_t e;
      accept(2'b10, 2'd0, 8'd1, n);
      for (int c = 1; c <= 10; c++) begin
         push(n + c, ev(c < 9, 2'd0, c == 9, 2'b10, 1'b0, c >= 9));
      end
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL zero_torque N+%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int   n;
      exp_t e;
      accept(2'b01, 2'd1, 8'd0, n);
      // Second command held pending for the whole first command
      cmd_if.cmd_dir      = 2'b11;
      cmd_if.cmd_torque   = 2'd0;
      cmd_if.cmd_duration = 8'd0;
      cmd_if.cmd_valid    = 1'b1;
      for (int c = 1; c <= 12; c++) push(n + c, ev(1'b1, (c < 5) ? 2'd0 : 2'd1, 1'b0, 2'b01, 0, 0));
      push(n + 13, ev(1'b0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b1));
      for (int c = 14; c <= 17; c++) push(n + c, ev(1'b1, 2'd0, 1'b0, 2'b11, 1'b0, 1'b0));
      push(n + 18, ev(1'b0, 2'd0, 1'b1, 2'b11, 1'b0, 1'b1));
      push(n + 19, ev(1'b0, 2'd0, 1'b0, 2'b11, 1'b0, 1'b1));
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL back_to_back N+%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
            if (cyc == n + 13) begin
               @(posedge clk);
               #1;
               cmd_if.cmd_valid = 1'b0;
            end
         end
      end
   endtask

   task automatic test_estop_hold;
      int   n;
      exp_t e;
      accept(2'b01, 2'd1, 8'd5, n);
      for (int c = 1; c <= 10; c++) push(n + c, ev(1'b1, (c < 5) ? 2'd0 : 2'd1, 1'b0, 2'b01, 0, 0));
      for (int c = 11; c <= 13; c++) push(n + c, ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b1, 1'b0));
      for (int c = 14; c <= 20; c++) push(n + c, ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b0, 1'b1));
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL estop_hold N+%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
            if (cyc == n + 10) estop = 1'b1;
            if (cyc == n + 13) estop = 1'b0;
         end
      end
   endtask

   task automatic test_estop_accept;
      int   n;
      exp_t e;
      cmd_if.cmd_dir      = 2'b10;
      cmd_if.cmd_torque   = 2'd2;
      cmd_if.cmd_duration = 8'd3;
      cmd_if.cmd_valid    = 1'b1;
      estop               = 1'b1;
      #1;
      n_chk++;
      if (obs !== ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL estop_ready_low: got %b, expected %b", obs, ev(0, 0, 0, 2'b01, 0, 0));
      end
      n = cyc;
      push(n + 1, ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b1, 1'b0));
      push(n + 2, ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b0, 1'b1));
      push(n + 3, ev(1'b0, 2'd0, 1'b0, 2'b01, 1'b0, 1'b1));
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL estop_accept +%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
            if (cyc == n + 1) begin
               cmd_if.cmd_valid = 1'b0;
               estop            = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset_ramp;
      int   n;
      exp_t e;
      logic [1:0] tq;
      accept(2'b11, 2'd3, 8'd1, n);
      for (int c = 1; c <= 10; c++) begin
         tq = (c < 5) ? 2'd0 : (c < 9) ? 2'd1 : 2'd2;
         push(n + c, ev(1'b1, tq, 1'b0, 2'b11, 1'b0, 1'b0));
      end
      for (int c = 11; c <= 14; c++) push(n + c, ev(1'b0, 2'd0, 1'b0, 2'b00, 1'b0, 1'b1));
      while (sb.size() > 0) begin
         @(negedge clk);
         if (cyc == sb[0].cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (obs !== e.v) begin
               n_fail++;
               $display("FAIL reset_ramp N+%0d: got %b, expected %b", cyc - n, obs, e.v);
            end
            if (cyc == n + 10) rst_n = 1'b0;
            if (cyc == n + 11) rst_n = 1'b1;
         end
      end
   endtask

   initial begin
      cmd_if.cmd_valid    = 1'b0;
      cmd_if.cmd_dir      = 2'b00;
      cmd_if.cmd_torque   = 2'd0;
      cmd_if.cmd_duration = '0;
      test_reset();
      test_full_cmd();
      test_zero_torque();
      test_back_to_back();
      test_estop_hold();
      test_estop_accept();
      test_reset_ramp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks done", n_chk);
      $fatal(1);
   end
endmodule
